// File: rtl/seg_scan_controller.sv
// Scans a 4-digit common-anode 7-segment display through one shared external decoder.
// Each digit gets a dark BLANK slot, then a lit SHOW slot. New values take effect only at frame boundaries.
module seg_scan_controller #(
  parameter int CLK_DIV      = 50000,
  parameter int BLANK_CYCLES = 16,
  parameter int CNT_W        = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [15:0] value,
  input  logic        load,
  input  logic        lz_blank,
  output logic [3:0]  bin,
  input  logic [6:0]  seven_in,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        frame_done
);

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam bit               SHOW_ONE   = (CLK_DIV == 1);

  state_t           state;
  logic [1:0]       digit;
  logic [CNT_W-1:0] cnt;
  logic [15:0]      disp;
  logic [15:0]      pend;
  logic             pend_v;

  logic             boundary;
  logic             fd_next;
  logic [3:0]       an_show;

  // Leading-zero test: digit k is dark when it and every higher nibble are zero.
  function automatic logic suppressed(input logic [15:0] d, input logic [1:0] k,
                                      input logic lz);
    case (k)
      2'd3:    return lz && (d[15:12] == 4'h0);
      2'd2:    return lz && (d[15:8] == 8'h00);
      2'd1:    return lz && (d[15:4] == 12'h000);
      default: return 1'b0;
    endcase
  endfunction

  // bin follows the current digit during BLANK as well, so seg is valid at the first SHOW cycle.
  assign bin = disp[{digit, 2'b00} +: 4];

  assign boundary = enable && ((state == IDLE) ||
                    (state == SHOW && digit == 2'd3 && cnt == SHOW_LAST));

  // frame_done is registered, so it is raised one edge before the final SHOW cycle of digit 3.
  assign fd_next = enable && (digit == 2'd3) &&
                   ((!SHOW_ONE && state == SHOW && cnt == SHOW_LAST - CNT_W'(1)) ||
                    ( SHOW_ONE && state == BLANK && cnt == BLANK_LAST));

  assign an_show = suppressed(disp, digit, lz_blank) ? 4'b1111 : ~(4'b0001 << digit);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      digit      <= 2'd0;
      cnt        <= '0;
      an         <= 4'b1111;
      seg        <= 7'b1111111;
      frame_done <= 1'b0;
      disp       <= 16'h0000;
      pend       <= 16'h0000;
      pend_v     <= 1'b0;
    end else begin
      // A load in the boundary cycle bypasses the pending register.
      if (boundary) begin
        if (load) begin
          disp   <= value;
          pend   <= value;
          pend_v <= 1'b0;
        end else if (pend_v) begin
          disp   <= pend;
          pend_v <= 1'b0;
        end
      end else if (load) begin
        pend   <= value;
        pend_v <= 1'b1;
      end

      frame_done <= fd_next;

      if (!enable) begin
        state <= IDLE;
        digit <= 2'd0;
        cnt   <= '0;
        an    <= 4'b1111;
        seg   <= 7'b1111111;
      end else begin
        case (state)
          IDLE: begin
            state <= BLANK;
            digit <= 2'd0;
            cnt   <= '0;
            an    <= 4'b1111;
            seg   <= 7'b1111111;
          end
          BLANK: begin
            seg <= seven_in;
            if (cnt == BLANK_LAST) begin
              state <= SHOW;
              cnt   <= '0;
              an    <= an_show;
            end else begin
              cnt <= cnt + CNT_W'(1);
              an  <= 4'b1111;
            end
          end
          SHOW: begin
            seg <= seven_in;
            if (cnt == SHOW_LAST) begin
              state <= BLANK;
              digit <= digit + 2'd1;
              cnt   <= '0;
              an    <= 4'b1111;
            end else begin
              cnt <= cnt + CNT_W'(1);
              an  <= an_show;
            end
          end
          default: begin
            state <= IDLE;
            digit <= 2'd0;
            cnt   <= '0;
            an    <= 4'b1111;
            seg   <= 7'b1111111;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_controller.sv
// Directed bench for seg_scan_controller with CLK_DIV=4 and BLANK_CYCLES=2 (24-cycle frames).
// An external hex decoder model drives seven_in. Each cycle of a frame is checked against expected values.
module tb_seg_scan_controller;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [15:0] value;
  logic        load;
  logic        lz_blank;
  logic [3:0]  bin;
  logic [6:0]  seven_in;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  seg_scan_controller #(.CLK_DIV(4), .BLANK_CYCLES(2), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .enable(enable), .value(value), .load(load),
    .lz_blank(lz_blank), .bin(bin), .seven_in(seven_in), .seg(seg), .an(an),
    .frame_done(frame_done)
  );

  // Clock and reset are driven from here.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] dec(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;  default: return 7'b0001110;
    endcase
  endfunction

  assign seven_in = dec(bin);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    check("an_onehot", 32'($countones(~an) <= 1), 32'd1);
  endtask

  // Checks ncyc cycles of one frame, starting at its first BLANK cycle, and applies up to two loads.
  task automatic run_frame(input logic [15:0] v, input logic lz, input int ncyc,
                           input int la, input logic [15:0] lav,
                           input int lb, input logic [15:0] lbv);
    for (int n = 0; n < ncyc; n++) begin
      int         slot;
      int         pos;
      logic       supp;
      logic [3:0] nib;
      logic [3:0] exp_an;
      slot   = n / 6;
      pos    = n % 6;
      nib    = v[slot*4 +: 4];
      supp   = lz && (slot > 0) && ((v >> (4*slot)) == 16'h0000);
      exp_an = (pos < 2 || supp) ? 4'b1111 : ~(4'b0001 << slot);
      check($sformatf("an c%0d", n), 32'(an), 32'(exp_an));
      check($sformatf("frame_done c%0d", n), 32'(frame_done), 32'(n == 23));
      if (pos >= 2) begin
        check($sformatf("seg c%0d", n), 32'(seg), 32'(dec(nib)));
        check($sformatf("bin c%0d", n), 32'(bin), 32'(nib));
      end
      if (n == la) begin load = 1'b1; value = lav; end
      if (n == lb) begin load = 1'b1; value = lbv; end
      tick();
      load = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; load = 1'b0; value = 16'h0000; lz_blank = 1'b0;
    #2;
    check("rst_an", 32'(an), 32'hF);
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_fd", 32'(frame_done), 32'd0);
    check("rst_bin", 32'(bin), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    tick();
    check("idle_an", 32'(an), 32'hF);
    check("idle_seg", 32'(seg), 32'h7F);

    // Enabling and loading in the same cycle applies the value to the first frame.
    enable = 1'b1; load = 1'b1; value = 16'h12AF;
    tick();
    load = 1'b0;
    run_frame(16'h12AF, 1'b0, 24,  8, 16'h1234, -1, 16'h0000);
    run_frame(16'h1234, 1'b0, 24, 12, 16'h0005, -1, 16'h0000);
    run_frame(16'h0005, 1'b0, 24,  5, 16'hAAAA, 10, 16'hBBBB);
    run_frame(16'hBBBB, 1'b0, 24,  3, 16'hDDDD, 23, 16'hCCCC);
    run_frame(16'hCCCC, 1'b0, 24,  4, 16'h0070, -1, 16'h0000);
    lz_blank = 1'b1;
    run_frame(16'h0070, 1'b1, 24,  7, 16'h0000, -1, 16'h0000);
    run_frame(16'h0000, 1'b1, 24,  9, 16'h4321, -1, 16'h0000);
    lz_blank = 1'b0;

    // Drop enable in the digit-2 SHOW slot: the display goes dark with no frame_done.
    run_frame(16'h4321, 1'b0, 16, -1, 16'h0000, -1, 16'h0000);
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("off_an %0d", i), 32'(an), 32'hF);
      check($sformatf("off_seg %0d", i), 32'(seg), 32'h7F);
      check($sformatf("off_fd %0d", i), 32'(frame_done), 32'd0);
    end
    enable = 1'b1;
    tick();
    run_frame(16'h4321, 1'b0, 24, -1, 16'h0000, -1, 16'h0000);

    // Assert reset between clock edges during a SHOW slot.
    run_frame(16'h4321, 1'b0, 16, -1, 16'h0000, -1, 16'h0000);
    #2 reset = 1'b1;
    #1;
    check("arst_an", 32'(an), 32'hF);
    check("arst_seg", 32'(seg), 32'h7F);
    check("arst_fd", 32'(frame_done), 32'd0);
    check("arst_bin", 32'(bin), 32'd0);
    #2 reset = 1'b0;
    tick();
    run_frame(16'h0000, 1'b0, 24, -1, 16'h0000, -1, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
